// File: rtl/inflow_pkg.sv
// Shared constants for the inflow demux slice.
//   PATH0 / PATH1 : path identifiers, matching the value of inflow_q
//   DEFAULT_DW    : default AXI-Stream data width
//   CNT_W         : width of the per-path packet counters
package inflow_pkg;

    localparam logic PATH0      = 1'b0;
    localparam logic PATH1      = 1'b1;
    localparam int   DEFAULT_DW = 512;
    localparam int   CNT_W      = 32;

endpackage

// File: rtl/inflow_demux_out_reg.sv
// axis_out_reg: single-stage AXI-Stream register slice, one per demux path.
// The parent decides when a beat is loaded. It only loads when can_load is
// high, so the payload never changes while the downstream stalls.
//   clk, resetn            clock, synchronous active-low reset
//   load                   capture in_* into the register this cycle
//   in_tdata/tkeep/tlast   beat to capture
//   out_tdata/tkeep/tlast  registered beat
//   out_tvalid             register holds a beat
//   out_tready             downstream accepts the registered beat
//   can_load               register is empty or is being drained this cycle
module axis_out_reg
    import inflow_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int KW = DW / 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [DW-1:0] in_tdata,
    input  logic [KW-1:0] in_tkeep,
    input  logic          in_tlast,
    output logic [DW-1:0] out_tdata,
    output logic [KW-1:0] out_tkeep,
    output logic          out_tlast,
    output logic          out_tvalid,
    input  logic          out_tready,
    output logic          can_load
);

    assign can_load = ~out_tvalid | out_tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_tvalid <= 1'b0;
        end else if (load) begin
            out_tvalid <= 1'b1;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

    // Payload needs no reset; it is only observed while out_tvalid is set.
    always_ff @(posedge clk) begin
        if (load) begin
            out_tdata <= in_tdata;
            out_tkeep <= in_tkeep;
            out_tlast <= in_tlast;
        end
    end

endmodule

// File: rtl/inflow_demux.sv
// inflow_demux: steers the inbound AXI-Stream to path 0 or path 1. The path is
// chosen from inflow_q when a packet starts and held until its tlast beat, so
// packets are never split. Each path has a one-beat output register.
//   clk, resetn                     clock, synchronous active-low reset
//   inflow_q                        requested path for the next packet
//   axis_in_*                       inbound stream
//   axis_out0_*, axis_out1_*        path streams
//   inflow_done0/1                  path is quiescent (registered level)
//   pkt_count0/1                    packets delivered per path
// Optional feature: define INFLOW_DEMUX_STATS_EN to build the packet counters;
// without it pkt_count0/1 are tied to zero.
module inflow_demux
    import inflow_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int KW = DW / 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inflow_q,
    input  logic [DW-1:0]    axis_in_tdata,
    input  logic [KW-1:0]    axis_in_tkeep,
    input  logic             axis_in_tlast,
    input  logic             axis_in_tvalid,
    output logic             axis_in_tready,
    output logic [DW-1:0]    axis_out0_tdata,
    output logic [KW-1:0]    axis_out0_tkeep,
    output logic             axis_out0_tlast,
    output logic             axis_out0_tvalid,
    input  logic             axis_out0_tready,
    output logic [DW-1:0]    axis_out1_tdata,
    output logic [KW-1:0]    axis_out1_tkeep,
    output logic             axis_out1_tlast,
    output logic             axis_out1_tvalid,
    input  logic             axis_out1_tready,
    output logic             inflow_done0,
    output logic             inflow_done1,
    output logic [CNT_W-1:0] pkt_count0,
    output logic [CNT_W-1:0] pkt_count1
);

    logic sel;
    logic mid_pkt;
    logic route;
    logic accept;
    logic can_load0;
    logic can_load1;
    logic load0;
    logic load1;

    // Inside a packet the path is locked to sel; between packets inflow_q
    // decides. Ready never looks at axis_in_tvalid.
    assign route          = mid_pkt ? sel : inflow_q;
    assign axis_in_tready = (route == PATH1) ? can_load1 : can_load0;
    assign accept         = axis_in_tvalid & axis_in_tready;
    assign load0          = accept & (route == PATH0);
    assign load1          = accept & (route == PATH1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel     <= PATH0;
            mid_pkt <= 1'b0;
        end else if (accept) begin
            if (!mid_pkt) begin
                sel <= inflow_q;
            end
            mid_pkt <= ~axis_in_tlast;
        end
    end

    // A path reports done only once nothing is headed for it: it is not
    // requested, no packet to it is open, and its register has drained.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            inflow_done0 <= 1'b0;
            inflow_done1 <= 1'b0;
        end else begin
            inflow_done0 <= (inflow_q != PATH0) && !(mid_pkt && (sel == PATH0))
                            && !axis_out0_tvalid;
            inflow_done1 <= (inflow_q != PATH1) && !(mid_pkt && (sel == PATH1))
                            && !axis_out1_tvalid;
        end
    end

    axis_out_reg #(.DW(DW), .KW(KW)) u_out0 (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load0),
        .in_tdata   (axis_in_tdata),
        .in_tkeep   (axis_in_tkeep),
        .in_tlast   (axis_in_tlast),
        .out_tdata  (axis_out0_tdata),
        .out_tkeep  (axis_out0_tkeep),
        .out_tlast  (axis_out0_tlast),
        .out_tvalid (axis_out0_tvalid),
        .out_tready (axis_out0_tready),
        .can_load   (can_load0)
    );

    axis_out_reg #(.DW(DW), .KW(KW)) u_out1 (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load1),
        .in_tdata   (axis_in_tdata),
        .in_tkeep   (axis_in_tkeep),
        .in_tlast   (axis_in_tlast),
        .out_tdata  (axis_out1_tdata),
        .out_tkeep  (axis_out1_tkeep),
        .out_tlast  (axis_out1_tlast),
        .out_tvalid (axis_out1_tvalid),
        .out_tready (axis_out1_tready),
        .can_load   (can_load1)
    );

`ifdef INFLOW_DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // A packet counts as delivered when its tlast beat leaves the register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (axis_out0_tvalid && axis_out0_tready && axis_out0_tlast) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (axis_out1_tvalid && axis_out1_tready && axis_out1_tlast) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign pkt_count0 = cnt0_q;
    assign pkt_count1 = cnt1_q;
`else
    assign pkt_count0 = '0;
    assign pkt_count1 = '0;
`endif

endmodule

// File: tb/tb_inflow_demux.sv
module tb_inflow_demux;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk;
    logic          resetn;
    logic          inflow_q;
    logic [DW-1:0] axis_in_tdata;
    logic [KW-1:0] axis_in_tkeep;
    logic          axis_in_tlast;
    logic          axis_in_tvalid;
    logic          axis_in_tready;
    logic [DW-1:0] axis_out0_tdata;
    logic [KW-1:0] axis_out0_tkeep;
    logic          axis_out0_tlast;
    logic          axis_out0_tvalid;
    logic          axis_out0_tready;
    logic [DW-1:0] axis_out1_tdata;
    logic [KW-1:0] axis_out1_tkeep;
    logic          axis_out1_tlast;
    logic          axis_out1_tvalid;
    logic          axis_out1_tready;
    logic          inflow_done0;
    logic          inflow_done1;
    logic [31:0]   pkt_count0;
    logic [31:0]   pkt_count1;

    inflow_demux #(.DW(DW), .KW(KW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .inflow_q         (inflow_q),
        .axis_in_tdata    (axis_in_tdata),
        .axis_in_tkeep    (axis_in_tkeep),
        .axis_in_tlast    (axis_in_tlast),
        .axis_in_tvalid   (axis_in_tvalid),
        .axis_in_tready   (axis_in_tready),
        .axis_out0_tdata  (axis_out0_tdata),
        .axis_out0_tkeep  (axis_out0_tkeep),
        .axis_out0_tlast  (axis_out0_tlast),
        .axis_out0_tvalid (axis_out0_tvalid),
        .axis_out0_tready (axis_out0_tready),
        .axis_out1_tdata  (axis_out1_tdata),
        .axis_out1_tkeep  (axis_out1_tkeep),
        .axis_out1_tlast  (axis_out1_tlast),
        .axis_out1_tvalid (axis_out1_tvalid),
        .axis_out1_tready (axis_out1_tready),
        .inflow_done0     (inflow_done0),
        .inflow_done1     (inflow_done1),
        .pkt_count0       (pkt_count0),
        .pkt_count1       (pkt_count1)
    );

    always #5 clk = ~clk;

    // Reference model: beats waiting at the input, and beats handed to each
    // path but not yet taken downstream (a one-deep register holds exactly these).
    beat_t       in_q[$];
    beat_t       q0[$];
    beat_t       q1[$];
    bit          m_sel;
    bit          m_mid;
    logic        e_done0;
    logic        e_done1;
    logic [31:0] e_cnt0;
    logic [31:0] e_cnt1;
    bit          gate;
    int          total;
    int          bad;

    function automatic beat_t mk_beat(bit last);
        beat_t b;
        for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom;
        b.k = {$urandom, $urandom};
        b.l = last;
        return b;
    endfunction

    task automatic push_pkt(int len);
        for (int i = 0; i < len; i++) in_q.push_back(mk_beat(i == len - 1));
    endtask

    function automatic bit e_route();
        return m_mid ? m_sel : inflow_q;
    endfunction

    // A path can take a beat when its register is empty or is being emptied.
    function automatic logic e_ready();
        if (e_route()) return (q1.size() == 0) || axis_out1_tready;
        return (q0.size() == 0) || axis_out0_tready;
    endfunction

    function automatic logic [31:0] exp_cnt(bit p);
`ifdef INFLOW_DEMUX_STATS_EN
        return p ? e_cnt1 : e_cnt0;
`else
        return 32'd0;
`endif
    endfunction

    task automatic drive_in();
        axis_in_tvalid = gate && (in_q.size() > 0);
        if (in_q.size() > 0) begin
            axis_in_tdata = in_q[0].d;
            axis_in_tkeep = in_q[0].k;
            axis_in_tlast = in_q[0].l;
        end else begin
            axis_in_tdata = '0;
            axis_in_tkeep = '0;
            axis_in_tlast = 1'b0;
        end
    endtask

    // Advance one clock: snapshot what happens at the edge, then apply it.
    task automatic tick();
        bit    acc, r, c0, c1, nd0, nd1;
        beat_t b;
        if (!resetn) begin
            @(posedge clk);
            q0.delete(); q1.delete();
            m_sel = 0; m_mid = 0;
            e_done0 = 0; e_done1 = 0;
            e_cnt0 = 0; e_cnt1 = 0;
            @(negedge clk);
            return;
        end
        acc = axis_in_tvalid && e_ready();
        r   = e_route();
        if (in_q.size() > 0) b = in_q[0];
        nd0 = (inflow_q != 1'b0) && !(m_mid && m_sel == 1'b0) && (q0.size() == 0);
        nd1 = (inflow_q != 1'b1) && !(m_mid && m_sel == 1'b1) && (q1.size() == 0);
        c0  = (q0.size() > 0) && axis_out0_tready;
        c1  = (q1.size() > 0) && axis_out1_tready;
        @(posedge clk);
        e_done0 = nd0;
        e_done1 = nd1;
        if (c0) begin if (q0[0].l) e_cnt0 = e_cnt0 + 1; void'(q0.pop_front()); end
        if (c1) begin if (q1[0].l) e_cnt1 = e_cnt1 + 1; void'(q1.pop_front()); end
        if (acc) begin
            if (r) q1.push_back(b); else q0.push_back(b);
            void'(in_q.pop_front());
            if (!m_mid) m_sel = r;
            m_mid = !b.l;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 0; gate = 0; inflow_q = 0;
        axis_out0_tready = 1; axis_out1_tready = 1;
        drive_in();
        repeat (3) tick();
        #1;
        total++; if (axis_in_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b want=1", axis_in_tready); end
        total++; if (axis_out0_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid0 got=%b want=0", axis_out0_tvalid); end
        total++; if (axis_out1_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid1 got=%b want=0", axis_out1_tvalid); end
        total++; if (inflow_done0 !== 1'b0) begin bad++; $display("FAIL reset_done0 got=%b want=0", inflow_done0); end
        total++; if (inflow_done1 !== 1'b0) begin bad++; $display("FAIL reset_done1 got=%b want=0", inflow_done1); end
        total++; if (dut.sel !== 1'b0 || dut.mid_pkt !== 1'b0) begin bad++; $display("FAIL reset_state got=%b%b want=00", dut.sel, dut.mid_pkt); end
        total++; if (pkt_count0 !== 32'd0 || pkt_count1 !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", pkt_count0, pkt_count1); end
        resetn = 1;
    endtask

    task automatic test_basic_path0();
        inflow_q = 0; axis_out0_tready = 1; axis_out1_tready = 1; gate = 1;
        push_pkt(4);
        for (int c = 0; c < 8; c++) begin
            drive_in(); #1;
            total++; if (axis_in_tready !== e_ready()) begin bad++; $display("FAIL basic_tready c=%0d got=%b want=%b", c, axis_in_tready, e_ready()); end
            total++; if (axis_out1_tvalid !== 1'b0) begin bad++; $display("FAIL basic_tvalid1 c=%0d got=%b want=0", c, axis_out1_tvalid); end
            total++; if (axis_out0_tvalid !== (q0.size() != 0)) begin bad++; $display("FAIL basic_tvalid0 c=%0d got=%b want=%b", c, axis_out0_tvalid, q0.size() != 0); end
            if (q0.size() != 0) begin
                total++; if ({axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast} !== q0[0]) begin bad++; $display("FAIL basic_data0 c=%0d got=%h want=%h", c, {axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast}, q0[0]); end
            end
            tick();
        end
        drive_in(); #1;
        total++; if (inflow_done1 !== 1'b1) begin bad++; $display("FAIL basic_done1 got=%b want=1", inflow_done1); end
        total++; if (inflow_done0 !== 1'b0) begin bad++; $display("FAIL basic_done0 got=%b want=0", inflow_done0); end
    endtask

    task automatic test_switch_midpkt();
        inflow_q = 0; axis_out0_tready = 1; axis_out1_tready = 1; gate = 1;
        push_pkt(4); push_pkt(2);
        for (int c = 0; c < 14; c++) begin
            if (in_q.size() <= 4) inflow_q = 1;
            drive_in(); #1;
            total++; if (axis_out0_tvalid !== (q0.size() != 0)) begin bad++; $display("FAIL switch_tvalid0 c=%0d got=%b want=%b", c, axis_out0_tvalid, q0.size() != 0); end
            total++; if (axis_out1_tvalid !== (q1.size() != 0)) begin bad++; $display("FAIL switch_tvalid1 c=%0d got=%b want=%b", c, axis_out1_tvalid, q1.size() != 0); end
            if (q0.size() != 0) begin
                total++; if ({axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast} !== q0[0]) begin bad++; $display("FAIL switch_data0 c=%0d got=%h want=%h", c, {axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast}, q0[0]); end
            end
            if (q1.size() != 0) begin
                total++; if ({axis_out1_tdata, axis_out1_tkeep, axis_out1_tlast} !== q1[0]) begin bad++; $display("FAIL switch_data1 c=%0d got=%h want=%h", c, {axis_out1_tdata, axis_out1_tkeep, axis_out1_tlast}, q1[0]); end
            end
            total++; if (inflow_done0 !== e_done0) begin bad++; $display("FAIL switch_done0 c=%0d got=%b want=%b", c, inflow_done0, e_done0); end
            total++; if (inflow_done1 !== e_done1) begin bad++; $display("FAIL switch_done1 c=%0d got=%b want=%b", c, inflow_done1, e_done1); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        inflow_q = 0; axis_out1_tready = 1; gate = 1;
        push_pkt(6);
        for (int c = 0; c < 22; c++) begin
            axis_out0_tready = (c < 2 || c >= 12);
            drive_in(); #1;
            total++; if (axis_in_tready !== e_ready()) begin bad++; $display("FAIL bp_tready c=%0d got=%b want=%b", c, axis_in_tready, e_ready()); end
            if (c == 6) begin
                total++; if (axis_in_tready !== 1'b0) begin bad++; $display("FAIL bp_stall c=%0d got=%b want=0", c, axis_in_tready); end
            end
            total++; if (axis_out0_tvalid !== (q0.size() != 0)) begin bad++; $display("FAIL bp_tvalid0 c=%0d got=%b want=%b", c, axis_out0_tvalid, q0.size() != 0); end
            if (q0.size() != 0) begin
                total++; if ({axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast} !== q0[0]) begin bad++; $display("FAIL bp_data0 c=%0d got=%h want=%h", c, {axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast}, q0[0]); end
            end
            tick();
        end
        total++; if (in_q.size() != 0 || q0.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d/%0d want=0/0", in_q.size(), q0.size()); end
    endtask

    task automatic test_back_to_back();
        axis_out0_tready = 1; axis_out1_tready = 1; gate = 1;
        repeat (12) push_pkt(1);
        for (int c = 0; c < 16; c++) begin
            inflow_q = c[0] ^ ($urandom_range(0, 3) == 0);
            drive_in(); #1;
            total++; if (axis_in_tready !== e_ready()) begin bad++; $display("FAIL b2b_tready c=%0d got=%b want=%b", c, axis_in_tready, e_ready()); end
            total++; if (axis_out0_tvalid !== (q0.size() != 0)) begin bad++; $display("FAIL b2b_tvalid0 c=%0d got=%b want=%b", c, axis_out0_tvalid, q0.size() != 0); end
            total++; if (axis_out1_tvalid !== (q1.size() != 0)) begin bad++; $display("FAIL b2b_tvalid1 c=%0d got=%b want=%b", c, axis_out1_tvalid, q1.size() != 0); end
            if (q0.size() != 0) begin
                total++; if ({axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast} !== q0[0]) begin bad++; $display("FAIL b2b_data0 c=%0d got=%h want=%h", c, {axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast}, q0[0]); end
            end
            if (q1.size() != 0) begin
                total++; if ({axis_out1_tdata, axis_out1_tkeep, axis_out1_tlast} !== q1[0]) begin bad++; $display("FAIL b2b_data1 c=%0d got=%h want=%h", c, {axis_out1_tdata, axis_out1_tkeep, axis_out1_tlast}, q1[0]); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midpkt();
        inflow_q = 1; axis_out0_tready = 1; axis_out1_tready = 1; gate = 1;
        push_pkt(5);
        for (int c = 0; c < 10 && in_q.size() > 3; c++) begin
            drive_in(); #1;
            tick();
        end
        // Third beat is on the bus when reset hits; the rest of the packet is abandoned.
        resetn = 0;
        drive_in(); #1;
        tick();
        in_q.delete();
        drive_in(); #1;
        total++; if (axis_out0_tvalid !== 1'b0 || axis_out1_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b%b want=00", axis_out0_tvalid, axis_out1_tvalid); end
        total++; if (dut.mid_pkt !== 1'b0) begin bad++; $display("FAIL rstmid_mid got=%b want=0", dut.mid_pkt); end
        resetn = 1; inflow_q = 0;
        push_pkt(3);
        for (int c = 0; c < 7; c++) begin
            drive_in(); #1;
            total++; if (axis_out1_tvalid !== (q1.size() != 0)) begin bad++; $display("FAIL rstmid_tvalid1 c=%0d got=%b want=%b", c, axis_out1_tvalid, q1.size() != 0); end
            total++; if (axis_out0_tvalid !== (q0.size() != 0)) begin bad++; $display("FAIL rstmid_tvalid0 c=%0d got=%b want=%b", c, axis_out0_tvalid, q0.size() != 0); end
            if (q0.size() != 0) begin
                total++; if ({axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast} !== q0[0]) begin bad++; $display("FAIL rstmid_data0 c=%0d got=%h want=%h", c, {axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast}, q0[0]); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            inflow_q = $urandom_range(0, 1);
            axis_out0_tready = ($urandom_range(0, 3) != 0);
            axis_out1_tready = ($urandom_range(0, 3) != 0);
            gate = ($urandom_range(0, 4) != 0);
            if (in_q.size() < 3) push_pkt($urandom_range(1, 5));
            drive_in(); #1;
            total++; if (axis_in_tready !== e_ready()) begin bad++; $display("FAIL rnd_tready c=%0d got=%b want=%b", c, axis_in_tready, e_ready()); end
            total++; if (axis_out0_tvalid !== (q0.size() != 0)) begin bad++; $display("FAIL rnd_tvalid0 c=%0d got=%b want=%b", c, axis_out0_tvalid, q0.size() != 0); end
            total++; if (axis_out1_tvalid !== (q1.size() != 0)) begin bad++; $display("FAIL rnd_tvalid1 c=%0d got=%b want=%b", c, axis_out1_tvalid, q1.size() != 0); end
            if (q0.size() != 0) begin
                total++; if ({axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast} !== q0[0]) begin bad++; $display("FAIL rnd_data0 c=%0d got=%h want=%h", c, {axis_out0_tdata, axis_out0_tkeep, axis_out0_tlast}, q0[0]); end
            end
            if (q1.size() != 0) begin
                total++; if ({axis_out1_tdata, axis_out1_tkeep, axis_out1_tlast} !== q1[0]) begin bad++; $display("FAIL rnd_data1 c=%0d got=%h want=%h", c, {axis_out1_tdata, axis_out1_tkeep, axis_out1_tlast}, q1[0]); end
            end
            total++; if (inflow_done0 !== e_done0 || inflow_done1 !== e_done1) begin bad++; $display("FAIL rnd_done c=%0d got=%b%b want=%b%b", c, inflow_done0, inflow_done1, e_done0, e_done1); end
            total++; if (pkt_count0 !== exp_cnt(0) || pkt_count1 !== exp_cnt(1)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d want=%0d/%0d", c, pkt_count0, pkt_count1, exp_cnt(0), exp_cnt(1)); end
            tick();
        end
    endtask

    task automatic test_stats();
        logic [31:0] want1;
        resetn = 0; gate = 0; in_q.delete();
        drive_in(); #1;
        tick();
        resetn = 1; inflow_q = 1; axis_out0_tready = 1; axis_out1_tready = 1; gate = 1;
        push_pkt(2); push_pkt(1); push_pkt(3);
        for (int c = 0; c < 40 && (in_q.size() + q0.size() + q1.size()) != 0; c++) begin
            drive_in(); #1;
            tick();
        end
        drive_in(); #1;
        total++; if (in_q.size() + q0.size() + q1.size() != 0) begin bad++; $display("FAIL stats_drain got=%0d want=0", in_q.size() + q0.size() + q1.size()); end
`ifdef INFLOW_DEMUX_STATS_EN
        want1 = 32'd3;
`else
        want1 = 32'd0;
`endif
        total++; if (pkt_count1 !== want1) begin bad++; $display("FAIL stats_cnt1 got=%0d want=%0d", pkt_count1, want1); end
        total++; if (pkt_count0 !== 32'd0) begin bad++; $display("FAIL stats_cnt0 got=%0d want=0", pkt_count0); end
`ifdef INFLOW_DEMUX_STATS_EN
        force dut.cnt1_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt1_q;
        e_cnt1 = 32'hFFFF_FFFF;
        #1;
        total++; if (pkt_count1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stats_preload got=%h want=ffffffff", pkt_count1); end
        push_pkt(2);
        for (int c = 0; c < 20 && (in_q.size() + q1.size()) != 0; c++) begin
            drive_in(); #1;
            tick();
        end
        drive_in(); #1;
        total++; if (pkt_count1 !== 32'd0) begin bad++; $display("FAIL stats_wrap got=%h want=00000000", pkt_count1); end
`endif
    endtask

    initial begin
        clk = 0; resetn = 0; inflow_q = 0; gate = 0;
        axis_out0_tready = 1; axis_out1_tready = 1;
        axis_in_tvalid = 0; axis_in_tdata = '0; axis_in_tkeep = '0; axis_in_tlast = 0;
        m_sel = 0; m_mid = 0; e_done0 = 0; e_done1 = 0; e_cnt0 = 0; e_cnt1 = 0;
        total = 0; bad = 0;
        @(negedge clk);
        test_reset();
        test_basic_path0();
        test_switch_midpkt();
        test_backpressure();
        test_back_to_back();
        test_reset_midpkt();
        test_random();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
